// File: rtl/axi_rw_arbiter_pkg.sv
// Shared encodings for the IF/MEM arbiter in front of the AXI master rw_* port.
package axi_rw_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic ARB_ID_IF  = 1'b0;
    localparam logic ARB_ID_MEM = 1'b1;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;
    localparam logic [2:0] SIZE_D = 3'd3;

endpackage

// File: rtl/axi_rw_arbiter_if.sv
// Bundle of requester-side and downstream rw_* signals around axi_rw_arbiter.
interface axi_rw_arbiter_if #(
    parameter int RW_DATA_WIDTH = 64,
    parameter int RW_ADDR_WIDTH = 64
);
    import axi_rw_arbiter_pkg::*;

    logic                     if_valid_i;
    logic [RW_ADDR_WIDTH-1:0] if_addr_i;
    logic [2:0]               if_size_i;
    logic                     if_ready_o;
    logic [RW_DATA_WIDTH-1:0] if_rdata_o;
    logic [1:0]               if_resp_o;

    logic                     mem_valid_i;
    logic                     mem_wen_i;
    logic [RW_ADDR_WIDTH-1:0] mem_addr_i;
    logic [2:0]               mem_size_i;
    logic [RW_DATA_WIDTH-1:0] mem_wdata_i;
    logic                     mem_ready_o;
    logic [RW_DATA_WIDTH-1:0] mem_rdata_o;
    logic [1:0]               mem_resp_o;

    logic                     rw_id_o;
    logic                     rw_cen_o;
    logic                     rw_wen_o;
    logic [RW_ADDR_WIDTH-1:0] rw_addr_o;
    logic [2:0]               rw_size_o;
    logic [RW_DATA_WIDTH-1:0] rw_wdata_o;
    logic                     rw_ready_i;
    logic [RW_DATA_WIDTH-1:0] rw_rdata_i;
    logic [1:0]               rw_resp_i;

    modport slave (
        input  if_valid_i, if_addr_i, if_size_i,
        output if_ready_o, if_rdata_o, if_resp_o,
        input  mem_valid_i, mem_wen_i, mem_addr_i, mem_size_i, mem_wdata_i,
        output mem_ready_o, mem_rdata_o, mem_resp_o,
        output rw_id_o, rw_cen_o, rw_wen_o, rw_addr_o, rw_size_o, rw_wdata_o,
        input  rw_ready_i, rw_rdata_i, rw_resp_i
    );

    modport master (
        output if_valid_i, if_addr_i, if_size_i,
        input  if_ready_o, if_rdata_o, if_resp_o,
        output mem_valid_i, mem_wen_i, mem_addr_i, mem_size_i, mem_wdata_i,
        input  mem_ready_o, mem_rdata_o, mem_resp_o,
        input  rw_id_o, rw_cen_o, rw_wen_o, rw_addr_o, rw_size_o, rw_wdata_o,
        output rw_ready_i, rw_rdata_i, rw_resp_i
    );

endinterface

// File: rtl/arb_pick2.sv
// Combinational two-way picker: req[1] = MEM, req[0] = IF; MEM wins unless rr_en.
module arb_pick2
    import axi_rw_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       rr_en,
    output logic [1:0] grant,
    output logic       id
);

    always_comb begin
        id    = ARB_ID_IF;
        grant = 2'b00;
        if (req == 2'b11) begin
            // Contention: alternate away from the previous winner when enabled.
            id = rr_en ? ~last_grant : ARB_ID_MEM;
        end else if (req[1]) begin
            id = ARB_ID_MEM;
        end
        if (|req) begin
            grant = (id == ARB_ID_MEM) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/axi_rw_arbiter.sv
// Shares the AXI master rw_* port between IF and MEM requesters.
// Build option: define AXI_ARB_ROUND_ROBIN_EN for round-robin on contention.
//
// state    | meaning
// ARB_IDLE | no owner; grant on any valid request
// ARB_BUSY | request latched, rw_cen_o high until rw_ready_i
module axi_rw_arbiter
    import axi_rw_arbiter_pkg::*;
#(
    parameter int RW_DATA_WIDTH = 64,
    parameter int RW_ADDR_WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    axi_rw_arbiter_if.slave    bus
);

    arb_state_e               state_q, state_d;
    logic                     owner_q, owner_d;
    logic                     wen_q, wen_d;
    logic [RW_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]               size_q, size_d;
    logic [RW_DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [1:0] pick_grant;
    logic       pick_id;
    logic       last_grant;
    logic       rr_en;
    logic       busy;

`ifdef AXI_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == ARB_IDLE && |pick_grant) begin
            last_grant_d = pick_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= ARB_ID_IF;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;
    assign rr_en      = 1'b1;
`else
    assign last_grant = ARB_ID_IF;
    assign rr_en      = 1'b0;
`endif

    arb_pick2 u_pick (
        .req        ({bus.mem_valid_i, bus.if_valid_i}),
        .last_grant (last_grant),
        .rr_en      (rr_en),
        .grant      (pick_grant),
        .id         (pick_id)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (|pick_grant) begin
                    state_d = ARB_BUSY;
                    owner_d = pick_id;
                    if (pick_id == ARB_ID_MEM) begin
                        wen_d   = bus.mem_wen_i;
                        addr_d  = bus.mem_addr_i;
                        size_d  = bus.mem_size_i;
                        wdata_d = bus.mem_wdata_i;
                    end else begin
                        wen_d   = 1'b0;
                        addr_d  = bus.if_addr_i;
                        size_d  = bus.if_size_i;
                        wdata_d = '0;
                    end
                end
            end
            ARB_BUSY: begin
                if (bus.rw_ready_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_ID_IF;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy = (state_q == ARB_BUSY);

    assign bus.rw_cen_o   = busy;
    assign bus.rw_id_o    = owner_q;
    assign bus.rw_wen_o   = wen_q;
    assign bus.rw_addr_o  = addr_q;
    assign bus.rw_size_o  = size_q;
    assign bus.rw_wdata_o = wdata_q;

    // Return path is gated by BUSY so a stray rw_ready_i in IDLE reaches nobody.
    assign bus.if_ready_o  = busy & (owner_q == ARB_ID_IF)  & bus.rw_ready_i;
    assign bus.mem_ready_o = busy & (owner_q == ARB_ID_MEM) & bus.rw_ready_i;
    assign bus.if_rdata_o  = (busy && owner_q == ARB_ID_IF)  ? bus.rw_rdata_i : '0;
    assign bus.if_resp_o   = (busy && owner_q == ARB_ID_IF)  ? bus.rw_resp_i  : 2'b00;
    assign bus.mem_rdata_o = (busy && owner_q == ARB_ID_MEM) ? bus.rw_rdata_i : '0;
    assign bus.mem_resp_o  = (busy && owner_q == ARB_ID_MEM) ? bus.rw_resp_i  : 2'b00;

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Directed self-checking bench for axi_rw_arbiter; honours AXI_ARB_ROUND_ROBIN_EN.
module tb_axi_rw_arbiter;
    import axi_rw_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    axi_rw_arbiter_if #(.RW_DATA_WIDTH(64), .RW_ADDR_WIDTH(64)) bus ();

    axi_rw_arbiter #(.RW_DATA_WIDTH(64), .RW_ADDR_WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic idle_inputs();
        bus.if_valid_i  = 1'b0;
        bus.if_addr_i   = '0;
        bus.if_size_i   = '0;
        bus.mem_valid_i = 1'b0;
        bus.mem_wen_i   = 1'b0;
        bus.mem_addr_i  = '0;
        bus.mem_size_i  = '0;
        bus.mem_wdata_i = '0;
        bus.rw_ready_i  = 1'b0;
        bus.rw_rdata_i  = '0;
        bus.rw_resp_i   = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        bus.rw_ready_i = 1'b1;
        #3;
        checks++; if (bus.rw_cen_o !== 1'b0) begin errors++; $display("FAIL rst_cen: got %b exp 0", bus.rw_cen_o); end
        checks++; if (bus.rw_id_o !== 1'b0) begin errors++; $display("FAIL rst_id: got %b exp 0", bus.rw_id_o); end
        checks++; if ({bus.rw_wen_o, bus.rw_size_o, bus.rw_addr_o, bus.rw_wdata_o} !== '0) begin
            errors++; $display("FAIL rst_fields: wen %b size %0d addr %h wdata %h exp all 0", bus.rw_wen_o, bus.rw_size_o, bus.rw_addr_o, bus.rw_wdata_o); end
        checks++; if ({bus.if_ready_o, bus.mem_ready_o} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b exp 00", {bus.if_ready_o, bus.mem_ready_o}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.rw_cen_o !== 1'b0 || bus.if_ready_o !== 1'b0 || bus.mem_ready_o !== 1'b0) begin
            errors++; $display("FAIL idle_ready_ignored: cen %b if_rdy %b mem_rdy %b exp 0 0 0", bus.rw_cen_o, bus.if_ready_o, bus.mem_ready_o); end
        bus.rw_ready_i = 1'b0;
    endtask

    task automatic test_if_read();
        @(negedge clk);
        bus.if_valid_i = 1'b1;
        bus.if_addr_i  = 64'h8000_0000;
        bus.if_size_i  = SIZE_W;
        #1;
        checks++; if (bus.rw_cen_o !== 1'b0) begin errors++; $display("FAIL if_cen_early: got %b exp 0", bus.rw_cen_o); end
        @(negedge clk);
        checks++; if (bus.rw_cen_o !== 1'b1) begin errors++; $display("FAIL if_cen_grant: got %b exp 1", bus.rw_cen_o); end
        checks++; if (bus.rw_id_o !== 1'b0) begin errors++; $display("FAIL if_id: got %b exp 0", bus.rw_id_o); end
        checks++; if (bus.rw_addr_o !== 64'h8000_0000 || bus.rw_size_o !== 3'd2 || bus.rw_wen_o !== 1'b0 || bus.rw_wdata_o !== 64'h0) begin
            errors++; $display("FAIL if_latch: addr %h size %0d wen %b wdata %h exp 80000000 2 0 0", bus.rw_addr_o, bus.rw_size_o, bus.rw_wen_o, bus.rw_wdata_o); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.rw_cen_o !== 1'b1 || bus.if_ready_o !== 1'b0) begin
                errors++; $display("FAIL if_wait%0d: cen %b if_rdy %b exp 1 0", i, bus.rw_cen_o, bus.if_ready_o); end
        end
        bus.rw_ready_i = 1'b1;
        bus.rw_rdata_i = 64'h1234;
        bus.rw_resp_i  = 2'b00;
        bus.if_valid_i = 1'b0;
        #1;
        checks++; if (bus.if_ready_o !== 1'b1 || bus.if_rdata_o !== 64'h1234) begin
            errors++; $display("FAIL if_done: rdy %b rdata %h exp 1 1234", bus.if_ready_o, bus.if_rdata_o); end
        checks++; if (bus.mem_ready_o !== 1'b0 || bus.mem_rdata_o !== 64'h0) begin
            errors++; $display("FAIL if_mem_quiet: rdy %b rdata %h exp 0 0", bus.mem_ready_o, bus.mem_rdata_o); end
        checks++; if (bus.rw_cen_o !== 1'b1) begin errors++; $display("FAIL if_cen_on_ready: got %b exp 1", bus.rw_cen_o); end
        @(negedge clk);
        bus.rw_ready_i = 1'b0;
        checks++; if (bus.rw_cen_o !== 1'b0 || bus.if_ready_o !== 1'b0) begin
            errors++; $display("FAIL if_after: cen %b rdy %b exp 0 0", bus.rw_cen_o, bus.if_ready_o); end
    endtask

    task automatic test_mem_write();
        logic stable = 1'b1;
        @(negedge clk);
        bus.mem_valid_i = 1'b1;
        bus.mem_wen_i   = 1'b1;
        bus.mem_addr_i  = 64'h8000_0010;
        bus.mem_wdata_i = 64'hDEAD_BEEF;
        bus.mem_size_i  = SIZE_D;
        @(negedge clk);
        checks++; if (bus.rw_id_o !== 1'b1 || bus.rw_wen_o !== 1'b1 || bus.rw_cen_o !== 1'b1) begin
            errors++; $display("FAIL mw_grant: id %b wen %b cen %b exp 1 1 1", bus.rw_id_o, bus.rw_wen_o, bus.rw_cen_o); end
        for (int i = 0; i < 3; i++) begin
            if (bus.rw_addr_o !== 64'h8000_0010 || bus.rw_wdata_o !== 64'hDEAD_BEEF || bus.rw_size_o !== 3'd3 || bus.rw_wen_o !== 1'b1) stable = 1'b0;
            @(negedge clk);
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL mw_stable: got %b exp 1", stable); end
        bus.rw_ready_i  = 1'b1;
        bus.rw_rdata_i  = 64'hAA;
        bus.rw_resp_i   = 2'b10;
        bus.mem_valid_i = 1'b0;
        #1;
        checks++; if (bus.mem_ready_o !== 1'b1 || bus.mem_resp_o !== 2'b10) begin
            errors++; $display("FAIL mw_done: rdy %b resp %b exp 1 10", bus.mem_ready_o, bus.mem_resp_o); end
        checks++; if (bus.if_ready_o !== 1'b0 || bus.if_resp_o !== 2'b00 || bus.if_rdata_o !== 64'h0) begin
            errors++; $display("FAIL mw_if_quiet: rdy %b resp %b rdata %h exp 0 00 0", bus.if_ready_o, bus.if_resp_o, bus.if_rdata_o); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_busy_input_change();
        @(negedge clk);
        bus.mem_valid_i = 1'b1;
        bus.mem_wen_i   = 1'b0;
        bus.mem_addr_i  = 64'h3000;
        bus.mem_size_i  = SIZE_W;
        @(negedge clk);
        bus.mem_addr_i = 64'h4000;
        @(negedge clk);
        checks++; if (bus.rw_addr_o !== 64'h3000) begin errors++; $display("FAIL chg_busy: got %h exp 3000", bus.rw_addr_o); end
        bus.rw_ready_i  = 1'b1;
        bus.mem_valid_i = 1'b0;
        @(negedge clk);
        bus.rw_ready_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.rw_addr_o !== 64'h3000 || bus.rw_cen_o !== 1'b0) begin
            errors++; $display("FAIL chg_idle: addr %h cen %b exp 3000 0", bus.rw_addr_o, bus.rw_cen_o); end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp_id;
`ifdef AXI_ARB_ROUND_ROBIN_EN
        exp_id = 3'b101;
`else
        exp_id = 3'b111;
`endif
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            bus.if_valid_i  = 1'b1;
            bus.if_addr_i   = 64'h100;
            bus.mem_valid_i = 1'b1;
            bus.mem_wen_i   = 1'b0;
            bus.mem_addr_i  = 64'h200;
            @(negedge clk);
            checks++; if (bus.rw_id_o !== exp_id[r]) begin errors++; $display("FAIL sim_id%0d: got %b exp %b", r, bus.rw_id_o, exp_id[r]); end
            checks++; if (bus.rw_addr_o !== (exp_id[r] ? 64'h200 : 64'h100)) begin
                errors++; $display("FAIL sim_addr%0d: got %h exp %h", r, bus.rw_addr_o, exp_id[r] ? 64'h200 : 64'h100); end
            bus.rw_ready_i  = 1'b1;
            bus.if_valid_i  = 1'b0;
            bus.mem_valid_i = 1'b0;
            #1;
            checks++; if ({bus.mem_ready_o, bus.if_ready_o} !== (exp_id[r] ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL sim_ready%0d: got %b exp %b", r, {bus.mem_ready_o, bus.if_ready_o}, exp_id[r] ? 2'b10 : 2'b01); end
            @(negedge clk);
            bus.rw_ready_i = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.if_valid_i = 1'b1;
        bus.if_addr_i  = 64'h1000;
        bus.if_size_i  = SIZE_D;
        @(negedge clk);
        checks++; if (bus.rw_cen_o !== 1'b1 || bus.rw_addr_o !== 64'h1000) begin
            errors++; $display("FAIL b2b_first: cen %b addr %h exp 1 1000", bus.rw_cen_o, bus.rw_addr_o); end
        bus.rw_ready_i = 1'b1;
        bus.if_addr_i  = 64'h2000;
        @(negedge clk);
        bus.rw_ready_i = 1'b0;
        checks++; if (bus.rw_cen_o !== 1'b0 || bus.rw_addr_o !== 64'h1000) begin
            errors++; $display("FAIL b2b_gap: cen %b addr %h exp 0 1000", bus.rw_cen_o, bus.rw_addr_o); end
        @(negedge clk);
        checks++; if (bus.rw_cen_o !== 1'b1 || bus.rw_addr_o !== 64'h2000) begin
            errors++; $display("FAIL b2b_second: cen %b addr %h exp 1 2000", bus.rw_cen_o, bus.rw_addr_o); end
        bus.rw_ready_i = 1'b1;
        bus.if_valid_i = 1'b0;
        @(negedge clk);
        bus.rw_ready_i = 1'b0;
        checks++; if (bus.rw_cen_o !== 1'b0) begin errors++; $display("FAIL b2b_end: cen %b exp 0", bus.rw_cen_o); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        bus.mem_valid_i = 1'b1;
        bus.mem_addr_i  = 64'h5000;
        @(negedge clk);
        bus.rw_ready_i = 1'b1;
        #1;
        checks++; if (bus.mem_ready_o !== 1'b1) begin errors++; $display("FAIL mid_pre: mem_rdy %b exp 1", bus.mem_ready_o); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rw_cen_o !== 1'b0 || bus.mem_ready_o !== 1'b0 || bus.if_ready_o !== 1'b0) begin
            errors++; $display("FAIL mid_async: cen %b mem_rdy %b if_rdy %b exp 0 0 0", bus.rw_cen_o, bus.mem_ready_o, bus.if_ready_o); end
        checks++; if (bus.rw_addr_o !== 64'h0 || bus.rw_id_o !== 1'b0) begin
            errors++; $display("FAIL mid_fields: addr %h id %b exp 0 0", bus.rw_addr_o, bus.rw_id_o); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.rw_cen_o !== 1'b0 || bus.rw_id_o !== 1'b0 || bus.rw_addr_o !== 64'h0) begin
            errors++; $display("FAIL mid_release: cen %b id %b addr %h exp 0 0 0", bus.rw_cen_o, bus.rw_id_o, bus.rw_addr_o); end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_mem_write();
        test_busy_input_change();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rw_arbiter.md
# axi_rw_arbiter

Two-requester arbiter in front of the AXI master interface's single `rw_*` user port. It shares that port between the instruction-fetch requester (read-only, `IF`) and the data-memory requester (read/write, `MEM`). It grants one requester, latches its request, holds `rw_cen_o` high until the transaction completes, and returns `rw_ready_i`, `rw_rdata_i` and `rw_resp_i` to the owning requester. It sits between the core pipeline and the AXI master interface.

## Interface
- `RW_DATA_WIDTH`, 64, data width of both requesters and the downstream port
- `RW_ADDR_WIDTH`, 64, address width
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `if_valid_i`  in  1  IF request; held until `if_ready_o`
- `if_addr_i`  in  RW_ADDR_WIDTH  IF address
- `if_size_i`  in  3  IF size code (0=B, 1=H, 2=W, 3=D)
- `if_ready_o`  out  1  one-cycle completion pulse to IF
- `if_rdata_o`  out  RW_DATA_WIDTH  IF read data; valid with `if_ready_o`
- `if_resp_o`  out  2  IF response; valid with `if_ready_o`
- `mem_valid_i`  in  1  MEM request; held until `mem_ready_o`
- `mem_wen_i`  in  1  1 = write, 0 = read
- `mem_addr_i`  in  RW_ADDR_WIDTH  MEM address
- `mem_size_i`  in  3  MEM size code
- `mem_wdata_i`  in  RW_DATA_WIDTH  MEM write data
- `mem_ready_o`  out  1  one-cycle completion pulse to MEM
- `mem_rdata_o`  out  RW_DATA_WIDTH  MEM read data
- `mem_resp_o`  out  2  MEM response
- `rw_id_o`  out  1  owner tag: 0 = IF, 1 = MEM
- `rw_cen_o`  out  1  transaction enable to the downstream port
- `rw_wen_o`  out  1  write enable
- `rw_addr_o`  out  RW_ADDR_WIDTH  latched address
- `rw_size_o`  out  3  latched size
- `rw_wdata_o`  out  RW_DATA_WIDTH  latched write data
- `rw_ready_i`  in  1  downstream completion pulse
- `rw_rdata_i`  in  RW_DATA_WIDTH  downstream read data
- `rw_resp_i`  in  2  downstream response

## Operation
- States: `IDLE`, `BUSY`.
- `IDLE` -> `BUSY` when `if_valid_i | mem_valid_i` at a rising edge.
  - On that edge, latch owner, `wen`, `addr`, `size` and `wdata` into registers.
  - For IF, latch `wen = 0` and `wdata = 0`.
- `BUSY` -> `IDLE` on the edge where `rw_ready_i = 1`.
- `BUSY` holds in every other case; there is no timeout.
- `rw_cen_o = (state == BUSY)`. It stays 1 through the `rw_ready_i` cycle, so the downstream FSMs leave their DONE state.
- All `rw_*` outputs come from registers and are constant for the whole of `BUSY`.
- Arbitration when both requesters are valid in `IDLE`: fixed priority, `MEM` wins.
- Return path:
  - `if_ready_o = BUSY & ~owner & rw_ready_i`
  - `mem_ready_o = BUSY & owner & rw_ready_i`
  - `*_rdata_o` and `*_resp_o` pass `rw_rdata_i` / `rw_resp_i` through to the owner; the non-owner sees 0.
- A non-zero response is forwarded unchanged; the arbiter takes no error action.
- A requester dropping valid while granted does not abort; the transaction completes and its ready pulse still fires.
- Reset values: state `IDLE`; every output 0; latched fields 0; `last_grant` 0 (IF).
- Asynchronous reset mid-`BUSY` forces `IDLE` immediately. Any downstream transfer in flight is abandoned, and the downstream block must be reset together with the arbiter.

## Timing
- Grant latency: `rw_cen_o` rises 1 cycle after valid is first sampled in `IDLE`.
- Completion: the requester's ready pulse is combinational, in the same cycle as `rw_ready_i`.
- Turnaround:
  - After the ready cycle the arbiter spends at least one `IDLE` cycle, so `rw_cen_o` is low for 1 cycle between transactions.
  - Back-to-back period is therefore transaction length + 1.
- Requesters must deassert or replace valid by the edge following their ready pulse. A still-high valid is treated as a new request.
- `rw_ready_i` while in `IDLE` is ignored.

## Configuration
- Macro `AXI_ARB_ROUND_ROBIN_EN`.
- Defined:
  - A `last_grant` register updates at every grant.
  - On simultaneous requests, grant the requester that did not win last time.
  - A lone request is granted regardless of `last_grant`.
- Undefined: fixed priority, `MEM` over `IF`, and no `last_grant` register is instantiated.

## Structure
- Shared package or defines holds:
  - state encodings `ARB_IDLE` / `ARB_BUSY`
  - owner IDs `ARB_ID_IF = 1'b0` / `ARB_ID_MEM = 1'b1`
  - size codes
- One sub-module, `arb_pick2`: combinational two-input picker. Inputs: `req[1:0]`, `last_grant`, `rr_en`. Outputs: `grant` and `id`. It contains the priority and round-robin logic.
- Request latch and FSM live in the top module.

## Test plan
- Single IF read: `if_valid_i = 1`, addr `0x8000_0000`, size 2; downstream returns `rw_ready_i` after 5 cycles with rdata `0x1234` -> `rw_cen_o` high 1 cycle after valid, `rw_id_o = 0`, `if_ready_o` pulses once with `if_rdata_o = 0x1234`, `mem_ready_o` stays 0.
- MEM write: wen 1, addr `0x8000_0010`, wdata `0xDEAD_BEEF`, size 3 -> `rw_wen_o = 1` and latched fields are stable while `rw_cen_o = 1`, `mem_ready_o` pulses, `mem_resp_o = rw_resp_i`.
- Simultaneous requests, three rounds with both valid and re-asserted:
  - without `AXI_ARB_ROUND_ROBIN_EN`: grants MEM, MEM, MEM;
  - with `AXI_ARB_ROUND_ROBIN_EN`: grants MEM, IF, MEM.
- Back-to-back IF requests -> `rw_cen_o` low for exactly 1 cycle between transactions, and the latched address updates only at the grant edge.
- Input change while `BUSY`: change `mem_addr_i` mid-transaction -> `rw_addr_o` is unchanged until the next grant.
- Reset mid-`BUSY`: assert `rst_n = 0` asynchronously -> `rw_cen_o` and every ready output go 0 without waiting for a clock edge; after release the state is `IDLE`.
